// File: rtl/fifo_reader_pkg.sv
// Shared constants and helpers for the FIFO reader.
// Holds the default data width, buffer depth and counter width.
package fifo_reader_pkg;

  localparam int DW    = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  typedef logic [1:0] occ_t;

  // True when the buffer can accept one more read result
  // after accounting for the read in flight and this cycle's pop.
  function automatic logic has_room(
    input occ_t cur_occ,
    input logic cur_inflight,
    input logic cur_pop
  );
    logic [2:0] load;
    load = {1'b0, cur_occ}
         + {2'b00, cur_inflight}
         - {2'b00, cur_pop};
    return load < 3'(DEPTH);
  endfunction

endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order buffer between FIFO read data and downstream.
// Ports: clk, rst, push, pop, din, dout (oldest entry), occ.
module fifo_reader_skid
  import fifo_reader_pkg::*;
#(
  parameter int dw = DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [dw-1:0] din,
  output logic [dw-1:0] dout,
  output occ_t          occ
);

  logic [dw-1:0] e0;
  logic [dw-1:0] e1;

  always_ff @(posedge clk) begin
    if (rst) begin
      e0  <= '0;
      e1  <= '0;
      occ <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            e0  <= din;
            occ <= 2'd1;
          end else if (occ == 2'd1) begin
            e1  <= din;
            occ <= 2'd2;
          end
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          // Occupancy holds; new data lands behind any
          // remaining entry so ordering is kept.
          if (occ == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign dout = e0;

endmodule

// File: rtl/fifo_reader.sv
// Drains a first-word-fall-through-less FIFO into a valid/ready stream.
// Ports: clk, rst, en, fifo_empty/fifo_re/fifo_dout, m_valid/m_ready/m_data, busy, xfer_cnt.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int dw = DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_re,
  input  logic [dw-1:0]    fifo_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [dw-1:0]    m_data,
  output logic             busy,
  output logic [CNT_W-1:0] xfer_cnt
);

  occ_t occ;
  logic inflight;
  logic pop;

  assign m_valid = occ != 2'd0;
  assign pop     = m_valid && m_ready;
  assign busy    = m_valid || inflight;

  // Reads are only issued when a slot is guaranteed at capture time.
  assign fifo_re = !rst && en && !fifo_empty
                 && has_room(occ, inflight, pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      xfer_cnt <= '0;
    end else begin
      inflight <= fifo_re;
      if (pop) begin
        xfer_cnt <= xfer_cnt + 1'b1;
      end
    end
  end

  // Data returned for a read issued before reset is dropped
  // because inflight is cleared by reset.
  fifo_reader_skid #(
    .dw(dw)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .push(inflight),
    .pop (pop),
    .din (fifo_dout),
    .dout(m_data),
    .occ (occ)
  );

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the only clock, and rst is sampled on the rising edge of clk.
REQ-002 Parameter dw, default 8, SHALL set the data width in bits.
REQ-003 Port clk, input, 1 bit: rising-edge clock.
REQ-004 Port rst, input, 1 bit: synchronous active-high reset.
REQ-005 Port en, input, 1 bit: when high, the block is permitted to issue new FIFO reads.
REQ-006 Port fifo_empty, input, 1 bit: empty flag from the FIFO read side.
REQ-007 Port fifo_re, output, 1 bit: read strobe to the FIFO.
REQ-008 Port fifo_dout, input, dw bits: FIFO read data, valid in the cycle after fifo_re is high.
REQ-009 Port m_valid, output, 1 bit: downstream data valid.
REQ-010 Port m_ready, input, 1 bit: downstream ready.
REQ-011 Port m_data, output, dw bits: downstream data.
REQ-012 Port busy, output, 1 bit: high when a read is in flight or the buffer is occupied.
REQ-013 Port xfer_cnt, output, 16 bits: count of completed downstream transfers.

Function
REQ-014 The block SHALL hold a 2-entry in-order buffer with occupancy occ (0..2) and an in-flight flag inflight (0/1).
REQ-015 A pop SHALL occur in a cycle exactly when m_valid && m_ready.
REQ-016 fifo_re SHALL be combinational: en && !fifo_empty && (occ + inflight - pop) < 2.
REQ-017 fifo_re high in cycle T SHALL set inflight for cycle T+1, and fifo_dout SHALL be written into the buffer at the end of cycle T+1.
REQ-018 m_valid SHALL equal (occ != 0), and m_data SHALL be the oldest buffer entry; the earliest m_valid after a read strobe in cycle T is cycle T+2.
REQ-019 While m_valid && !m_ready, m_data and m_valid SHALL remain stable.
REQ-020 A write and a pop in the same cycle SHALL leave occ unchanged and preserve ordering.
REQ-021 With m_ready held high and the FIFO non-empty, sustained throughput SHALL be one transfer per cycle.
REQ-022 The buffer SHALL never overflow; a write when occ == 2 and no pop is a design error and SHALL be unreachable.
REQ-023 Deasserting en SHALL stop new fifo_re only: an in-flight read is still captured, and buffered data is still delivered.
REQ-024 xfer_cnt SHALL increment by 1 on each pop and wrap from 16'hFFFF to 0.
REQ-025 busy SHALL equal (occ != 0) || inflight.

Reset
REQ-026 On rst: occ = 0, inflight = 0, m_valid = 0, m_data = 0, xfer_cnt = 0, busy = 0.
REQ-027 fifo_re SHALL be 0 in every cycle in which rst is high.
REQ-028 Reset asserted mid-operation SHALL discard buffered and in-flight data; FIFO data returned after reset SHALL be ignored.

Structure
REQ-029 A shared package SHALL hold the dw default (8), the buffer depth constant (2), and the xfer_cnt width (16).
REQ-030 The 2-entry buffer SHALL be a sub-module named fifo_reader_skid (push, pop, din, dout, occ).
REQ-031 The top level SHALL hold the read-issue logic, the inflight flag, and the counter.

Verification
REQ-032 Bench SHALL cover: reset, then en = 1, FIFO preloaded with 8'h11, 8'h22, 8'h33, m_ready = 1 -> fifo_re in cycles 0, 1, 2; m_data 11, 22, 33 in cycles 2, 3, 4; xfer_cnt = 3; busy = 0 by cycle 5.
REQ-033 Bench SHALL cover: m_ready = 0, FIFO holding 4 bytes -> exactly 2 reads issued, occ = 2, m_data stable at the first byte; then m_ready = 1 -> all 4 bytes delivered in order.
REQ-034 Bench SHALL cover: fifo_empty = 1 throughout with en = 1 -> fifo_re, m_valid, and busy stay 0.
REQ-035 Bench SHALL cover: en dropped in the same cycle as a read strobe -> that byte is still delivered and no further fifo_re occurs.
REQ-036 Bench SHALL cover: rst pulsed while occ = 2 and inflight = 1 -> next cycle m_valid = 0, xfer_cnt = 0, and no stale byte ever appears on m_data.
REQ-037 Bench SHALL cover: preload xfer_cnt to 16'hFFFF via 65535 transfers, then 1 more transfer -> xfer_cnt = 0.
